microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Parametrised next-generation control unit for the EDiC CPU datapath.
- Fetches an instruction through a valid/ready handshake and latches it.
- Walks a variable-length microprogram held in an external asynchronous-read control store, addressed by {flags, instruction, step}.
- Drives the datapath control word; supports stall, early end of instruction, halt/continue and step-overflow detection.
- Single rising clock edge only, no negedge logic.

Parameters:
INSTR_W, 8, instruction register width
STEP_W, 3, microstep counter width (max 2^STEP_W steps per instruction)
CTRL_W, 16, control word width driven to datapath
FLAG_W, 2, number of ALU flags folded into control-store address
IMM_LSB, 3, LSB position of immediate field in instruction
IMM_W, 3, immediate field width (IMM_LSB+IMM_W <= INSTR_W)
ALU_OP_W, 3, low instruction bits forwarded as ALU mode
STALL_MASK, 16'h7FFF, control bits forced to 0 while stalled (write/load enables)
HLT_OPCODE, all ones, opcode that enters HALT

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  synchronous reset, active-low (0 = reset)
i_instruction  in  INSTR_W  instruction from memory/bus
i_instrValid  in  1  i_instruction valid this cycle
o_instrReq  out  1  sequencer ready to accept instruction
i_flags  in  FLAG_W  live ALU flags
i_flagsWr  in  1  capture i_flags into flag register
i_stall  in  1  freeze current microstep (memory wait)
i_continue  in  1  leave HALT
o_csAddr  out  FLAG_W+INSTR_W+STEP_W  control store address {r_flags, r_instr, r_step}
i_csData  in  CTRL_W+1  control store word; MSB = uEnd (last step)
o_ctrl  out  CTRL_W  datapath control word
o_aluMode  out  ALU_OP_W  r_instr[ALU_OP_W-1:0]
o_immediate  out  INSTR_W  zero-extended r_instr[IMM_LSB +: IMM_W]
o_hlt  out  1  in HALT state
o_stepOverflow  out  1  sticky: instruction ran out of steps without uEnd

Behaviour:
- States: FETCH, EXECUTE, HALT; registered state, r_instr, r_step, r_flags, overflow flag.
- Reset (i_reset=0 at rising edge): state=FETCH, r_instr=0, r_step=0, r_flags=0, o_stepOverflow=0. During reset o_instrReq=0, o_ctrl=0, o_hlt=0. Reset mid-instruction aborts immediately; no partial step completes.
- o_csAddr always = {r_flags, r_instr, r_step}; o_aluMode and o_immediate combinational from r_instr.
- FETCH:
  - o_instrReq=1 (when not in reset), o_ctrl=0.
  - On edge with i_instrValid=1: r_instr<=i_instruction, r_step<=0.
  - If i_instruction==HLT_OPCODE then state<=HALT, else state<=EXECUTE.
  - i_instrValid=0 holds in FETCH indefinitely.
- EXECUTE:
  - o_instrReq=0, o_ctrl=i_csData[CTRL_W-1:0].
  - If i_stall=1: o_ctrl = word & ~STALL_MASK; r_step and state held.
  - Else if uEnd=1: state<=FETCH, r_step<=0.
  - Else if r_step==2^STEP_W-1: state<=FETCH, r_step<=0, o_stepOverflow<=1 (forced end).
  - Else r_step<=r_step+1.
  - Stall has priority over uEnd.
- HALT:
  - o_hlt=1, o_ctrl=0, o_instrReq=0.
  - i_continue=1 at edge: state<=FETCH.
  - Only reset or i_continue exits; r_instr keeps HLT_OPCODE.
- Flags: r_flags<=i_flags on any non-reset edge with i_flagsWr=1, in any state. A same-cycle flag write affects the address from the next cycle only.
- Timing: instruction accepted at edge N; step k drives o_ctrl in cycle N+1+k. With uEnd at step k, o_instrReq=1 again in cycle N+2+k. An instruction with k+1 steps and no stalls costs 1+(k+1) cycles including the accept cycle.
- o_stepOverflow clears only on reset.

Test Plan:
- Reset then release, i_instrValid=1 with 8'h21, store gives uEnd at step 2 -> o_instrReq high one cycle; o_csAddr steps {00,21,0..2}; o_instrReq high 4 cycles after accept; o_immediate=8'h04; o_aluMode=3'b001.
- i_stall=1 for 3 cycles at step 1 with word 17'h0FFFF -> o_ctrl=16'h8000 during stall; r_step stays 1 for 4 cycles total; step 2 follows.
- Store never sets uEnd for opcode 8'h10 -> 8 steps (0..7) execute; then FETCH; o_stepOverflow=1 and stays 1 across the next instruction.
- i_flags=2'b10 with i_flagsWr=1 at step 0 -> o_csAddr flag field becomes 2'b10 from step 1; no change if i_flagsWr=0.
- Fetch 8'hFF -> o_hlt=1, o_ctrl=0, o_instrReq=0 for 10 cycles; pulse i_continue -> o_instrReq=1 next cycle.
- Assert i_reset=0 at step 3 of a 6-step instruction -> next cycle o_ctrl=0, r_step=0; after release, FETCH with r_instr=0.

Source files
------------

// File: rtl/microcode_sequencer_if.sv
// Fetch, control-store and datapath signals of the microcode sequencer.
// master = sequencer side, slave = memory/control-store/datapath side.
interface microcode_sequencer_if #(
  parameter int INSTR_W  = 8,
  parameter int STEP_W   = 3,
  parameter int CTRL_W   = 16,
  parameter int FLAG_W   = 2,
  parameter int ALU_OP_W = 3
);
  logic [INSTR_W-1:0]               i_instruction;
  logic                             i_instrValid;
  logic                             o_instrReq;
  logic [FLAG_W-1:0]                i_flags;
  logic                             i_flagsWr;
  logic                             i_stall;
  logic                             i_continue;
  logic [FLAG_W+INSTR_W+STEP_W-1:0] o_csAddr;
  logic [CTRL_W:0]                  i_csData;
  logic [CTRL_W-1:0]                o_ctrl;
  logic [ALU_OP_W-1:0]              o_aluMode;
  logic [INSTR_W-1:0]               o_immediate;
  logic                             o_hlt;
  logic                             o_stepOverflow;

  modport master (
    input  i_instruction, i_instrValid, i_flags, i_flagsWr, i_stall, i_continue, i_csData,
    output o_instrReq, o_csAddr, o_ctrl, o_aluMode, o_immediate, o_hlt, o_stepOverflow
  );

  modport slave (
    output i_instruction, i_instrValid, i_flags, i_flagsWr, i_stall, i_continue, i_csData,
    input  o_instrReq, o_csAddr, o_ctrl, o_aluMode, o_immediate, o_hlt, o_stepOverflow
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Microprogram sequencer: fetch (1 cycle), then one control word per step until uEnd/overflow.
// Backpressure: i_instrValid low holds FETCH; i_stall freezes the step and masks write enables.
module microcode_sequencer #(
  parameter int                 INSTR_W    = 8,
  parameter int                 STEP_W     = 3,
  parameter int                 CTRL_W     = 16,
  parameter int                 FLAG_W     = 2,
  parameter int                 IMM_LSB    = 3,
  parameter int                 IMM_W      = 3,
  parameter int                 ALU_OP_W   = 3,
  parameter logic [CTRL_W-1:0]  STALL_MASK = 16'h7FFF,
  parameter logic [INSTR_W-1:0] HLT_OPCODE = '1
) (
  input logic                   i_clk,
  input logic                   i_reset,
  microcode_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_FETCH, S_EXECUTE, S_HALT} state_t;

  localparam logic [STEP_W-1:0] STEP_LAST = '1;

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                ovf_q, ovf_d;

  logic                u_end;
  logic [CTRL_W-1:0]   cs_word;
  logic                instr_req;
  logic                hlt;
  logic [CTRL_W-1:0]   ctrl;

  assign u_end   = bus.i_csData[CTRL_W];
  assign cs_word = bus.i_csData[CTRL_W-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= S_FETCH;
      instr_q <= '0;
      step_q  <= '0;
      flags_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      step_q  <= step_d;
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    step_d  = step_q;
    ovf_d   = ovf_q;
    flags_d = bus.i_flagsWr ? bus.i_flags : flags_q;
    case (state_q)
      S_FETCH: begin
        if (bus.i_instrValid) begin
          instr_d = bus.i_instruction;
          step_d  = '0;
          state_d = (bus.i_instruction == HLT_OPCODE) ? S_HALT : S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        // A stalled step is replayed, so it may neither end nor advance.
        if (!bus.i_stall) begin
          if (u_end) begin
            state_d = S_FETCH;
            step_d  = '0;
          end else if (step_q == STEP_LAST) begin
            state_d = S_FETCH;
            step_d  = '0;
            ovf_d   = 1'b1;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      S_HALT: begin
        if (bus.i_continue) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instr_req = 1'b0;
    hlt       = 1'b0;
    ctrl      = '0;
    if (i_reset) begin
      case (state_q)
        S_FETCH:   instr_req = 1'b1;
        S_EXECUTE: ctrl = bus.i_stall ? (cs_word & ~STALL_MASK) : cs_word;
        S_HALT:    hlt = 1'b1;
        default:   ;
      endcase
    end
  end

  assign bus.o_instrReq     = instr_req;
  assign bus.o_hlt          = hlt;
  assign bus.o_ctrl         = ctrl;
  assign bus.o_csAddr       = {flags_q, instr_q, step_q};
  assign bus.o_aluMode      = instr_q[ALU_OP_W-1:0];
  assign bus.o_immediate    = INSTR_W'(instr_q[IMM_LSB +: IMM_W]);
  assign bus.o_stepOverflow = ovf_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboarded bench: expected {address, control word} per executed step is queued at accept time.
module tb_microcode_sequencer;

  typedef struct {
    logic [12:0] addr;
    logic [15:0] ctrl;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [16:0] cs_mem [0:8191];
  exp_t        exp_q [$];
  logic [1:0]  flags_m;
  int          checks;
  int          errors;

  microcode_sequencer_if bus ();

  microcode_sequencer dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  assign bus.i_csData = cs_mem[bus.o_csAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] mk_addr(input logic [1:0] f, input logic [7:0] ins,
                                          input logic [2:0] s);
    return {f, ins, s};
  endfunction

  function automatic logic [15:0] ctrl_of(input logic [12:0] a);
    return {3'b110, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] ins);
    bus.i_instruction = ins;
    bus.i_instrValid  = 1'b1;
    tick();
    bus.i_instrValid  = 1'b0;
  endtask

  task automatic push_steps(input logic [7:0] ins, input int first, input int last);
    exp_t e;
    for (int k = first; k <= last; k++) begin
      e.addr = mk_addr(flags_m, ins, 3'(k));
      e.ctrl = ctrl_of(e.addr);
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    #2;
    checks += 3;
    if (bus.o_instrReq !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", bus.o_instrReq); end
    if (bus.o_ctrl !== 16'h0) begin errors++; $display("FAIL rst_ctrl: got %h expected 0000", bus.o_ctrl); end
    if (bus.o_hlt !== 1'b0) begin errors++; $display("FAIL rst_hlt: got %b expected 0", bus.o_hlt); end
    rst_n = 1'b1;
    #1;
    checks += 3;
    if (bus.o_csAddr !== 13'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0000", bus.o_csAddr); end
    if (bus.o_stepOverflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", bus.o_stepOverflow); end
    if (bus.o_instrReq !== 1'b1) begin errors++; $display("FAIL rst_release_req: got %b expected 1", bus.o_instrReq); end
  endtask

  task automatic test_basic();
    exp_t e;
    int   n;
    cs_mem[mk_addr(2'b00, 8'h21, 3'd2)][16] = 1'b1;
    bus.i_instruction = 8'h21;
    bus.i_instrValid  = 1'b1;
    #2;
    checks++;
    if (bus.o_instrReq !== 1'b1) begin errors++; $display("FAIL basic_req_pre: got %b expected 1", bus.o_instrReq); end
    push_steps(8'h21, 0, 2);
    accept(8'h21);
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      #2;
      if (bus.o_instrReq === 1'b0 && bus.o_hlt === 1'b0) begin
        e = exp_q.pop_front();
        checks += 2;
        if (bus.o_csAddr !== e.addr) begin errors++; $display("FAIL basic_addr: got %h expected %h", bus.o_csAddr, e.addr); end
        if (bus.o_ctrl !== e.ctrl) begin errors++; $display("FAIL basic_ctrl: got %h expected %h", bus.o_ctrl, e.ctrl); end
      end
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_timeout: %0d steps left expected 0", exp_q.size()); end
    exp_q.delete();
    #2;
    checks += 4;
    if (n != 3) begin errors++; $display("FAIL basic_len: got %0d cycles expected 3", n); end
    if (bus.o_instrReq !== 1'b1) begin errors++; $display("FAIL basic_req_post: got %b expected 1", bus.o_instrReq); end
    if (bus.o_immediate !== 8'h04) begin errors++; $display("FAIL basic_imm: got %h expected 04", bus.o_immediate); end
    if (bus.o_aluMode !== 3'b001) begin errors++; $display("FAIL basic_alu: got %b expected 001", bus.o_aluMode); end
  endtask

  task automatic test_stall();
    exp_t e;
    int   n;
    cs_mem[mk_addr(2'b00, 8'h22, 3'd1)] = 17'h0FFFF;
    cs_mem[mk_addr(2'b00, 8'h22, 3'd2)][16] = 1'b1;
    push_steps(8'h22, 0, 0);
    for (int k = 0; k < 3; k++) begin
      e.addr = mk_addr(2'b00, 8'h22, 3'd1);
      e.ctrl = 16'h8000;
      exp_q.push_back(e);
    end
    e.ctrl = 16'hFFFF;
    exp_q.push_back(e);
    push_steps(8'h22, 2, 2);
    accept(8'h22);
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      bus.i_stall = (n >= 1 && n <= 3);
      #2;
      if (bus.o_instrReq === 1'b0 && bus.o_hlt === 1'b0) begin
        e = exp_q.pop_front();
        checks += 2;
        if (bus.o_csAddr !== e.addr) begin errors++; $display("FAIL stall_addr: got %h expected %h", bus.o_csAddr, e.addr); end
        if (bus.o_ctrl !== e.ctrl) begin errors++; $display("FAIL stall_ctrl: got %h expected %h", bus.o_ctrl, e.ctrl); end
      end
      tick();
      n++;
    end
    bus.i_stall = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_timeout: %0d steps left expected 0", exp_q.size()); end
    exp_q.delete();
    #2;
    checks += 2;
    if (n != 6) begin errors++; $display("FAIL stall_len: got %0d cycles expected 6", n); end
    if (bus.o_instrReq !== 1'b1) begin errors++; $display("FAIL stall_req_post: got %b expected 1", bus.o_instrReq); end
  endtask

  task automatic test_overflow();
    exp_t e;
    int   n;
    checks++;
    if (bus.o_stepOverflow !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b expected 0", bus.o_stepOverflow); end
    push_steps(8'h10, 0, 7);
    accept(8'h10);
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      #2;
      if (bus.o_instrReq === 1'b0 && bus.o_hlt === 1'b0) begin
        e = exp_q.pop_front();
        checks += 3;
        if (bus.o_csAddr !== e.addr) begin errors++; $display("FAIL ovf_addr: got %h expected %h", bus.o_csAddr, e.addr); end
        if (bus.o_ctrl !== e.ctrl) begin errors++; $display("FAIL ovf_ctrl: got %h expected %h", bus.o_ctrl, e.ctrl); end
        if (bus.o_stepOverflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", bus.o_stepOverflow); end
      end
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_timeout: %0d steps left expected 0", exp_q.size()); end
    exp_q.delete();
    #2;
    checks += 3;
    if (n != 8) begin errors++; $display("FAIL ovf_len: got %0d cycles expected 8", n); end
    if (bus.o_instrReq !== 1'b1) begin errors++; $display("FAIL ovf_req_post: got %b expected 1", bus.o_instrReq); end
    if (bus.o_stepOverflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.o_stepOverflow); end
    push_steps(8'h21, 0, 2);
    accept(8'h21);
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      #2;
      if (bus.o_instrReq === 1'b0 && bus.o_hlt === 1'b0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.o_csAddr !== e.addr) begin errors++; $display("FAIL ovf2_addr: got %h expected %h", bus.o_csAddr, e.addr); end
      end
      tick();
      n++;
    end
    exp_q.delete();
    #2;
    checks++;
    if (bus.o_stepOverflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.o_stepOverflow); end
  endtask

  task automatic test_flags();
    exp_t e;
    int   n;
    cs_mem[mk_addr(2'b10, 8'h23, 3'd2)][16] = 1'b1;
    push_steps(8'h23, 0, 0);
    flags_m = 2'b10;
    push_steps(8'h23, 1, 2);
    accept(8'h23);
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      bus.i_flagsWr = (n == 0);
      bus.i_flags   = (n == 0) ? 2'b10 : 2'b01;
      #2;
      if (bus.o_instrReq === 1'b0 && bus.o_hlt === 1'b0) begin
        e = exp_q.pop_front();
        checks += 2;
        if (bus.o_csAddr !== e.addr) begin errors++; $display("FAIL flags_addr: got %h expected %h", bus.o_csAddr, e.addr); end
        if (bus.o_ctrl !== e.ctrl) begin errors++; $display("FAIL flags_ctrl: got %h expected %h", bus.o_ctrl, e.ctrl); end
      end
      tick();
      n++;
    end
    bus.i_flagsWr = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL flags_timeout: %0d steps left expected 0", exp_q.size()); end
    exp_q.delete();
    tick();
    #2;
    checks += 2;
    if (bus.o_csAddr[12:11] !== 2'b10) begin errors++; $display("FAIL flags_hold: got %b expected 10", bus.o_csAddr[12:11]); end
    if (bus.o_instrReq !== 1'b1) begin errors++; $display("FAIL flags_req_post: got %b expected 1", bus.o_instrReq); end
  endtask

  task automatic test_halt();
    accept(8'hFF);
    for (int c = 0; c < 10; c++) begin
      #2;
      checks += 4;
      if (bus.o_hlt !== 1'b1) begin errors++; $display("FAIL halt_hlt: got %b expected 1", bus.o_hlt); end
      if (bus.o_ctrl !== 16'h0) begin errors++; $display("FAIL halt_ctrl: got %h expected 0000", bus.o_ctrl); end
      if (bus.o_instrReq !== 1'b0) begin errors++; $display("FAIL halt_req: got %b expected 0", bus.o_instrReq); end
      if (bus.o_csAddr[10:3] !== 8'hFF) begin errors++; $display("FAIL halt_instr: got %h expected ff", bus.o_csAddr[10:3]); end
      tick();
    end
    bus.i_continue = 1'b1;
    tick();
    bus.i_continue = 1'b0;
    #2;
    checks += 2;
    if (bus.o_instrReq !== 1'b1) begin errors++; $display("FAIL halt_cont_req: got %b expected 1", bus.o_instrReq); end
    if (bus.o_hlt !== 1'b0) begin errors++; $display("FAIL halt_cont_hlt: got %b expected 0", bus.o_hlt); end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int   n;
    cs_mem[mk_addr(flags_m, 8'h31, 3'd5)][16] = 1'b1;
    push_steps(8'h31, 0, 2);
    accept(8'h31);
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      #2;
      if (bus.o_instrReq === 1'b0 && bus.o_hlt === 1'b0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.o_csAddr !== e.addr) begin errors++; $display("FAIL mrst_addr: got %h expected %h", bus.o_csAddr, e.addr); end
      end
      tick();
      n++;
    end
    exp_q.delete();
    #2;
    checks++;
    if (bus.o_csAddr !== mk_addr(flags_m, 8'h31, 3'd3)) begin
      errors++; $display("FAIL mrst_step3: got %h expected %h", bus.o_csAddr, mk_addr(flags_m, 8'h31, 3'd3));
    end
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (bus.o_ctrl !== 16'h0) begin errors++; $display("FAIL mrst_ctrl_in: got %h expected 0000", bus.o_ctrl); end
    if (bus.o_instrReq !== 1'b0) begin errors++; $display("FAIL mrst_req_in: got %b expected 0", bus.o_instrReq); end
    tick();
    rst_n = 1'b1;
    flags_m = 2'b00;
    #2;
    checks += 4;
    if (bus.o_csAddr !== 13'h0) begin errors++; $display("FAIL mrst_addr_post: got %h expected 0000", bus.o_csAddr); end
    if (bus.o_ctrl !== 16'h0) begin errors++; $display("FAIL mrst_ctrl_post: got %h expected 0000", bus.o_ctrl); end
    if (bus.o_instrReq !== 1'b1) begin errors++; $display("FAIL mrst_req_post: got %b expected 1", bus.o_instrReq); end
    if (bus.o_stepOverflow !== 1'b0) begin errors++; $display("FAIL mrst_ovf: got %b expected 0", bus.o_stepOverflow); end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    flags_m           = 2'b00;
    rst_n             = 1'b0;
    bus.i_instruction = 8'h00;
    bus.i_instrValid  = 1'b0;
    bus.i_flags       = 2'b00;
    bus.i_flagsWr     = 1'b0;
    bus.i_stall       = 1'b0;
    bus.i_continue    = 1'b0;
    for (int a = 0; a < 8192; a++) cs_mem[a] = {1'b0, ctrl_of(13'(a))};

    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_flags();
    test_halt();
    test_mid_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
